oc8051_intc: RTL

Parametrised, nestable interrupt controller for the oc8051 core. It generalises the fixed five-source, two-level controller to up to 16 sources and four priority levels, with per-source edge/level mode. It sits on the SFR bus for register access and drives the core's interrupt request/vector handshake (`intr`/`int_vec`/`ack`/`reti`).

---
 rtl/oc8051_intc_if.sv | 27 ++
 rtl/oc8051_intc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/oc8051_intc_if.sv
// Bus bundle for the oc8051 interrupt controller: SFR access plus the
// core's request/vector handshake.
interface oc8051_intc_if #(
    parameter int NSRC = 8
);
    logic [NSRC-1:0] src;
    logic            wr;
    logic [7:0]      wr_addr;
    logic [7:0]      data_in;
    logic [7:0]      rd_addr;
    logic [7:0]      data_out;
    logic            intr;
    logic [7:0]      int_vec;
    logic            ack;
    logic            reti;
    logic [2:0]      act_lev;

    modport master (
        output src, wr, wr_addr, data_in, rd_addr, ack, reti,
        input  data_out, intr, int_vec, act_lev
    );

    modport slave (
        input  src, wr, wr_addr, data_in, rd_addr, ack, reti,
        output data_out, intr, int_vec, act_lev
    );
endinterface

// File: rtl/oc8051_intc.sv
// Nestable interrupt controller: up to 16 sources, four priority levels,
// per-source edge/level mode, registers on the SFR bus.
module oc8051_intc #(
    parameter int         NSRC     = 8,
    parameter logic [7:0] BASE     = 8'hA8,
    parameter logic [7:0] VEC_BASE = 8'h03,
    parameter logic [7:0] VEC_STEP = 8'h08
) (
    input logic          clk,
    input logic          rst,
    oc8051_intc_if.slave bus
);
    // Internal state is always 16 wide; bits at or above NSRC stay zero.
    localparam logic [15:0] SRC_MASK = 16'((32'h1 << NSRC) - 1);

    logic             ea;
    logic [15:0]      ien;
    logic [15:0]      mode;
    logic [15:0]      pend_edge;
    logic [15:0][1:0] pri;
    logic [3:0]       active;
    logic [3:0]       idx_q;
    logic [1:0]       lev_q;
    logic             intr_q;
    logic [7:0]       vec_q;
    logic [7:0]       data_q;
    logic [15:0]      src_q;

    logic [15:0] src_ext;
    logic [15:0] pend;
    logic [15:0] cand;
    logic [15:0] rise;
    logic [7:0]  wr_off;
    logic [7:0]  rd_off;
    logic [10:0] wsel;
    logic [7:0]  rd_val;

    always_comb begin
        src_ext = '0;
        src_ext[NSRC-1:0] = bus.src;
    end

    assign rise   = src_ext & ~src_q;
    assign pend   = ((mode & pend_edge) | (~mode & src_ext)) & SRC_MASK;
    assign cand   = pend & ien & {16{ea}};
    assign wr_off = bus.wr_addr - BASE;
    assign rd_off = bus.rd_addr - BASE;

    always_comb begin
        for (int k = 0; k < 11; k++)
            wsel[k] = bus.wr && (wr_off == 8'(k));
    end

    // Arbitration: scan high to low with >= so ties settle on the lowest index.
    logic       found;
    logic [3:0] best_idx;
    logic [1:0] best_pri;

    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_pri = '0;
        for (int i = 15; i >= 0; i--) begin
            if (cand[i] && (!found || pri[i] >= best_pri)) begin
                found    = 1'b1;
                best_idx = 4'(i);
                best_pri = pri[i];
            end
        end
    end

    logic       cur_any;
    logic [1:0] cur_lev;

    always_comb begin
        cur_lev = '0;
        for (int i = 0; i < 4; i++)
            if (active[i]) cur_lev = 2'(i);
    end

    assign cur_any = |active;

    logic       req_ok;
    logic       ack_ok;
    logic [7:0] vec;

    assign req_ok = found && (!cur_any || best_pri > cur_lev);
    assign ack_ok = bus.ack && intr_q;
    assign vec    = VEC_BASE + 8'(best_idx) * VEC_STEP;

    // reti pops the top level before ack pushes the latched one.
    logic [3:0] active_nxt;
    logic       popped;

    always_comb begin
        active_nxt = active;
        popped     = 1'b0;
        if (bus.reti) begin
            for (int i = 3; i >= 0; i--) begin
                if (!popped && active_nxt[i]) begin
                    active_nxt[i] = 1'b0;
                    popped        = 1'b1;
                end
            end
        end
        if (ack_ok) active_nxt[lev_q] = 1'b1;
    end

    // Edge pending priority: register write, then fresh edge, then ack clear.
    logic [15:0] pend_raw;

    always_comb begin
        pend_raw = pend_edge;
        for (int i = 0; i < 16; i++) begin
            if ((i < 8 && wsel[5]) || (i >= 8 && wsel[6]))
                pend_raw[i] = bus.data_in[i % 8];
            else if (rise[i])
                pend_raw[i] = 1'b1;
            else if (ack_ok && idx_q == 4'(i))
                pend_raw[i] = 1'b0;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (rd_off)
            8'd0:  rd_val = {ea, 7'b0};
            8'd1:  rd_val = ien[7:0];
            8'd2:  rd_val = ien[15:8];
            8'd3:  rd_val = mode[7:0];
            8'd4:  rd_val = mode[15:8];
            8'd5:  rd_val = pend[7:0];
            8'd6:  rd_val = pend[15:8];
            8'd7:  rd_val = {pri[3],  pri[2],  pri[1],  pri[0]};
            8'd8:  rd_val = {pri[7],  pri[6],  pri[5],  pri[4]};
            8'd9:  rd_val = {pri[11], pri[10], pri[9],  pri[8]};
            8'd10: rd_val = {pri[15], pri[14], pri[13], pri[12]};
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea        <= 1'b0;
            ien       <= '0;
            mode      <= '0;
            pend_edge <= '0;
            pri       <= '0;
            active    <= '0;
            idx_q     <= '0;
            lev_q     <= '0;
            intr_q    <= 1'b0;
            vec_q     <= 8'h00;
            data_q    <= 8'h00;
            src_q     <= '0;
        end else begin
            src_q     <= src_ext;
            pend_edge <= pend_raw & mode & SRC_MASK;
            active    <= active_nxt;

            if (ack_ok) begin
                intr_q <= 1'b0;
                vec_q  <= 8'h00;
            end else begin
                intr_q <= req_ok;
                vec_q  <= req_ok ? vec : 8'h00;
                if (req_ok) begin
                    idx_q <= best_idx;
                    lev_q <= best_pri;
                end
            end

            if (bus.wr && bus.wr_addr == bus.rd_addr) data_q <= bus.data_in;
            else                                      data_q <= rd_val;

            if (wsel[0]) ea          <= bus.data_in[7];
            if (wsel[1]) ien[7:0]    <= bus.data_in & SRC_MASK[7:0];
            if (wsel[2]) ien[15:8]   <= bus.data_in & SRC_MASK[15:8];
            if (wsel[3]) mode[7:0]   <= bus.data_in & SRC_MASK[7:0];
            if (wsel[4]) mode[15:8]  <= bus.data_in & SRC_MASK[15:8];
            for (int k = 0; k < 4; k++) begin
                if (wsel[7+k]) begin
                    for (int j = 0; j < 4; j++)
                        pri[4*k+j] <= SRC_MASK[4*k+j] ? bus.data_in[2*j +: 2] : 2'b00;
                end
            end
        end
    end

    assign bus.intr     = intr_q;
    assign bus.int_vec  = vec_q;
    assign bus.data_out = data_q;
    assign bus.act_lev  = cur_any ? ({1'b0, cur_lev} + 3'd1) : 3'd0;
endmodule
